// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder/subtractor: one full-adder slice and a carry flop,
// LSB first, with a start/busy/done handshake and registered sum/cout/ovf.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Handshake: start is accepted only in IDLE or DONE, which makes the
  // request/ack pair (start, accept) a valid/ready transfer. Requests seen
  // while busy=1 are dropped, not queued. done pulses for one cycle per
  // accepted operation that was not cut short by reset.
  state_t state;
  state_t state_next;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_next;
  logic [WIDTH-1:0] sum_q;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             s_bit;
  logic             c_next;
  logic             accept;
  logic             last_bit;
  logic             cout_q;
  logic             ovf_q;

  always_comb begin
    accept     = start && ((state == IDLE) || (state == DONE));
    last_bit   = (state == RUN) && (cnt == CW'(WIDTH - 1));
    s_bit      = op_a[0] ^ op_b[0] ^ carry;
    c_next     = (op_a[0] & op_b[0]) | (op_a[0] & carry) | (op_b[0] & carry);
    // New bits enter at the MSB so that after WIDTH shifts bit i sits at i.
    shreg_next = shreg >> 1;
    shreg_next[WIDTH-1] = s_bit;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    state_next = accept ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a   <= '0;
      op_b   <= '0;
      shreg  <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (accept) begin
      // Subtraction is a + ~b + 1; the +1 comes in as the initial carry.
      op_a  <= a;
      op_b  <= sub ? ~b : b;
      carry <= sub;
      cnt   <= '0;
      shreg <= '0;
    end else if (state == RUN) begin
      op_a  <= op_a >> 1;
      op_b  <= op_b >> 1;
      carry <= c_next;
      shreg <= shreg_next;
      cnt   <= cnt + CW'(1);
      if (last_bit) begin
        // On the last bit, carry still holds the carry into the MSB.
        sum_q  <= shreg_next;
        cout_q <= c_next;
        ovf_q  <= carry ^ c_next;
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder at WIDTH 8, 1 and 32: vector table, directed
// handshake/reset sequences and random operations against an arithmetic model.
module tb_serial_adder;

  logic        clk;
  logic        rst_n;
  logic [2:0]  start_v;
  logic [2:0]  sub_v;
  logic [31:0] a_v [3];
  logic [31:0] b_v [3];
  logic [2:0]  busy_v;
  logic [2:0]  done_v;
  logic [2:0]  cout_v;
  logic [2:0]  ovf_v;
  logic [31:0] sum_v [3];
  logic [7:0]  sum8;
  logic [0:0]  sum1;
  logic [31:0] sum32;

  int checks = 0;
  int errors = 0;
  int wtab [3] = '{8, 1, 32};

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .sub(sub_v[0]),
    .a(a_v[0][7:0]), .b(b_v[0][7:0]), .busy(busy_v[0]), .done(done_v[0]),
    .sum(sum8), .cout(cout_v[0]), .ovf(ovf_v[0])
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .sub(sub_v[1]),
    .a(a_v[1][0:0]), .b(b_v[1][0:0]), .busy(busy_v[1]), .done(done_v[1]),
    .sum(sum1), .cout(cout_v[1]), .ovf(ovf_v[1])
  );

  serial_adder #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .sub(sub_v[2]),
    .a(a_v[2]), .b(b_v[2]), .busy(busy_v[2]), .done(done_v[2]),
    .sum(sum32), .cout(cout_v[2]), .ovf(ovf_v[2])
  );

  assign sum_v[0] = {24'b0, sum8};
  assign sum_v[1] = {31'b0, sum1};
  assign sum_v[2] = sum32;

  // clock/reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int          k;
    logic        s;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input int k, input logic st, input logic s,
                       input logic [31:0] x, input logic [31:0] y);
    start_v[k] = st;
    sub_v[k]   = s;
    a_v[k]     = x;
    b_v[k]     = y;
  endtask

  // Signed/unsigned arithmetic on the operands; returns {ovf, cout, sum}.
  function automatic logic [33:0] model(input int w, input logic s,
                                        input logic [31:0] x, input logic [31:0] y);
    longint mask, ux, uy, sx, sy, r, half, full;
    logic [31:0] sm;
    logic c, o;
    full = longint'(1) << w;
    half = longint'(1) << (w - 1);
    mask = full - 1;
    ux = longint'(x) & mask;
    uy = longint'(y) & mask;
    sx = (ux >= half) ? ux - full : ux;
    sy = (uy >= half) ? uy - full : uy;
    r  = s ? sx - sy : sx + sy;
    o  = (r < -half) || (r >= half);
    c  = s ? (ux >= uy) : ((ux + uy) >= full);
    sm = 32'(s ? ((ux - uy) & mask) : ((ux + uy) & mask));
    return {o, c, sm};
  endfunction

  // Runs one operation on instance k; checks latency, busy span and done width.
  task automatic run_op(input int k, input logic s, input logic [31:0] x,
                        input logic [31:0] y, output logic [31:0] rs,
                        output logic rc, output logic ro);
    int n;
    int nb;
    @(negedge clk);
    drive(k, 1'b1, s, x, y);
    @(posedge clk); #1;
    drive(k, 1'b0, 1'($urandom), $urandom, $urandom);
    n  = 0;
    nb = 0;
    while (!done_v[k] && n < 200) begin
      if (busy_v[k]) nb++;
      @(posedge clk); #1;
      n++;
    end
    check($sformatf("latency_w%0d", wtab[k]), n, wtab[k]);
    check($sformatf("busy_span_w%0d", wtab[k]), nb, wtab[k]);
    rs = sum_v[k];
    rc = cout_v[k];
    ro = ovf_v[k];
    @(posedge clk); #1;
    check($sformatf("done_width_w%0d", wtab[k]), done_v[k], 0);
  endtask

  task automatic check_result(input string nm, input logic [31:0] rs, input logic rc,
                              input logic ro, input logic [33:0] e);
    check({nm, "_sum"}, rs, e[31:0]);
    check({nm, "_cout"}, rc, e[32]);
    check({nm, "_ovf"}, ro, e[33]);
  endtask

  initial begin
    logic [31:0] rs;
    logic rc, ro;
    logic [31:0] x, y;
    logic s;
    int n, pulses;

    vecs[0] = '{0, 1'b0, 32'h3C, 32'h45, 32'h81, 1'b0, 1'b1};
    vecs[1] = '{0, 1'b0, 32'hFF, 32'h01, 32'h00, 1'b1, 1'b0};
    vecs[2] = '{0, 1'b1, 32'h10, 32'h20, 32'hF0, 1'b0, 1'b0};
    vecs[3] = '{0, 1'b1, 32'h80, 32'h01, 32'h7F, 1'b1, 1'b1};
    vecs[4] = '{0, 1'b0, 32'h02, 32'h03, 32'h05, 1'b0, 1'b0};
    vecs[5] = '{0, 1'b0, 32'h7F, 32'h01, 32'h80, 1'b0, 1'b1};
    vecs[6] = '{1, 1'b0, 32'h1, 32'h1, 32'h0, 1'b1, 1'b1};
    vecs[7] = '{1, 1'b1, 32'h0, 32'h1, 32'h1, 1'b0, 1'b1};
    vecs[8] = '{2, 1'b0, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b1, 1'b0};
    vecs[9] = '{2, 1'b1, 32'h0, 32'h1, 32'hFFFFFFFF, 1'b0, 1'b0};

    for (int k = 0; k < 3; k++) drive(k, 1'b0, 1'b0, 32'h0, 32'h0);
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset_busy_w%0d", wtab[k]), busy_v[k], 0);
      check($sformatf("reset_done_w%0d", wtab[k]), done_v[k], 0);
      check($sformatf("reset_sum_w%0d", wtab[k]), sum_v[k], 0);
      check($sformatf("reset_cout_w%0d", wtab[k]), cout_v[k], 0);
      check($sformatf("reset_ovf_w%0d", wtab[k]), ovf_v[k], 0);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // vector table
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].k, vecs[i].s, vecs[i].x, vecs[i].y, rs, rc, ro);
      check_result($sformatf("vec%0d", i), rs, rc, ro,
                   {vecs[i].ovf, vecs[i].cout, vecs[i].sum});
    end

    // result hold through idle cycles and through the following run
    run_op(0, 1'b1, 32'h80, 32'h01, rs, rc, ro);
    check_result("hold_setup", rs, rc, ro, {1'b1, 1'b1, 32'h7F});
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("hold_idle_sum", sum_v[0], 32'h7F);
    end
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 32'h02, 32'h03);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    n = 0;
    while (!done_v[0] && n < 50) begin
      check("hold_run_sum", sum_v[0], 32'h7F);
      @(posedge clk); #1;
      n++;
    end
    check("hold_new_sum", sum_v[0], 32'h05);
    @(posedge clk); #1;

    // start pulsed while busy is ignored
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 32'h3C, 32'h45);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    drive(0, 1'b1, 1'b0, 32'h01, 32'h01);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    pulses = 0;
    rs = 32'h0;
    for (int i = 0; i < 25; i++) begin
      if (done_v[0]) begin
        pulses++;
        rs = sum_v[0];
      end
      @(posedge clk); #1;
    end
    check("ignored_start_pulses", pulses, 1);
    check("ignored_start_sum", rs, 32'h81);

    // back-to-back: start held during DONE
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 32'h3C, 32'h45);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    n = 0;
    while (!done_v[0] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("b2b_first_latency", n, 8);
    check("b2b_first_sum", sum_v[0], 32'h81);
    drive(0, 1'b1, 1'b0, 32'h02, 32'h03);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("b2b_no_idle_busy", busy_v[0], 1);
    n = 1;
    while (!done_v[0] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("b2b_gap", n, 9);
    check("b2b_second_sum", sum_v[0], 32'h05);
    @(posedge clk); #1;
    check("b2b_done_drop", done_v[0], 0);

    // asynchronous reset in the middle of an operation
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 32'h3C, 32'h45);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_busy", busy_v[0], 0);
    check("async_rst_done", done_v[0], 0);
    check("async_rst_sum", sum_v[0], 0);
    check("async_rst_cout", cout_v[0], 0);
    check("async_rst_ovf", ovf_v[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done_v[0]) pulses++;
    end
    check("async_rst_no_done", pulses, 0);
    run_op(0, 1'b0, 32'h7F, 32'h01, rs, rc, ro);
    check_result("after_rst", rs, rc, ro, {1'b1, 1'b0, 32'h80});

    // random operations against the model
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 25; i++) begin
        s = 1'($urandom_range(0, 1));
        x = $urandom;
        y = $urandom;
        if ($urandom_range(0, 7) == 0) y = x;
        run_op(k, s, x, y, rs, rc, ro);
        check_result($sformatf("rand_w%0d_%0d", wtab[k], i), rs, rc, ro,
                     model(wtab[k], s, x, y));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
